// File: rtl/tetris_pkg.sv
// Shared types for the playfield: cell coordinates, four-cell pieces and the lock FSM states.
package tetris_pkg;

  localparam int DEF_COLS = 10;
  localparam int DEF_ROWS = 20;

  typedef logic [3:0] col_t;
  typedef logic [4:0] row_t;

  typedef struct packed {
    col_t col;
    row_t row;
  } cell_t;

  typedef cell_t [3:0] cells_t;

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} lock_state_t;

  // Cell k sits at cols[4k+3:4k] / rows[5k+4:5k] on the mover bus.
  function automatic cells_t unpack_cells(input logic [15:0] cols, input logic [19:0] rows);
    cells_t c;
    for (int k = 0; k < 4; k++) begin
      c[k].col = cols[4*k +: 4];
      c[k].row = rows[5*k +: 5];
    end
    return c;
  endfunction

  function automatic logic cell_in_range(input cell_t c, input int cols, input int rows);
    return (int'(c.col) < cols) && (int'(c.row) < rows);
  endfunction

endpackage

// File: rtl/piece_collide.sv
// Combinational landing test: a live piece must stop when any in-range cell is on the
// bottom row or sits directly above an occupied cell.
module piece_collide
  import tetris_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic                       piece_valid,
  input  cells_t                     cells,
  input  logic [ROWS-1:0][COLS-1:0]  grid,
  output logic                       stop_cond
);

  always_comb begin
    // NOTE: default first so every path assigns stop_cond and no latch is inferred.
    stop_cond = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (piece_valid && cell_in_range(cells[k], COLS, ROWS)) begin
        if (int'(cells[k].row) == ROWS - 1)
          stop_cond = 1'b1;
        else if (grid[cells[k].row + 5'd1][cells[k].col])
          stop_cond = 1'b1;
      end
    end
  end

endmodule

// File: rtl/playfield_lock.sv
// Playfield occupancy grid with piece lock, bottom-up full-row scan and collapse.
// Optional top-out detection is enabled by defining TOPOUT_DETECT_EN.
module playfield_lock
  import tetris_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic        frame_clk,
  input  logic        reset,
  input  logic        piece_valid,
  input  logic [15:0] cell_col,
  input  logic [19:0] cell_row,
  input  logic [3:0]  rd_col,
  input  logic [4:0]  rd_row,
  output logic        rd_occupied,
  output logic        stop,
  output logic        busy,
  output logic        lock_done,
  output logic [2:0]  lines_cleared,
  output logic [9:0]  total_lines,
  output logic        game_over
);

  logic [ROWS-1:0][COLS-1:0] grid;
  lock_state_t               state;
  row_t                      r;
  logic                      armed;
  logic [2:0]                count;
  cells_t                    cells;
  logic                      stop_cond;
  logic                      lock_blocked;
  logic [10:0]               total_sum;
  logic [9:0]                total_next;

  assign cells = unpack_cells(cell_col, cell_row);

  piece_collide #(.COLS(COLS), .ROWS(ROWS)) u_collide (
    .piece_valid (piece_valid),
    .cells       (cells),
    .grid        (grid),
    .stop_cond   (stop_cond)
  );

  assign busy = (state != IDLE);
  assign stop = busy | stop_cond;

  always_comb begin
    rd_occupied = 1'b0;
    if (int'(rd_col) < COLS && int'(rd_row) < ROWS)
      rd_occupied = grid[rd_row][rd_col];
  end

  assign total_sum  = {1'b0, total_lines} + {8'd0, count};
  assign total_next = total_sum[10] ? 10'd1023 : total_sum[9:0];

`ifdef TOPOUT_DETECT_EN
  logic top_hit;

  always_comb begin
    top_hit = 1'b0;
    for (int k = 0; k < 4; k++)
      if (cell_in_range(cells[k], COLS, ROWS) && cells[k].row == '0)
        top_hit = 1'b1;
  end

  assign lock_blocked = game_over;
`else
  assign lock_blocked = 1'b0;
  assign game_over    = 1'b0;
`endif

  always_ff @(posedge frame_clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the grid is plain flops, not RAM, so it can be cleared in one reset edge.
      grid          <= '0;
      state         <= IDLE;
      r             <= '0;
      armed         <= 1'b1;
      count         <= '0;
      lock_done     <= 1'b0;
      lines_cleared <= '0;
      total_lines   <= '0;
`ifdef TOPOUT_DETECT_EN
      game_over     <= 1'b0;
`endif
    end else begin
      lock_done <= 1'b0;
      // A dropped piece_valid re-arms the lock for the next piece, even while busy.
      if (!piece_valid)
        armed <= 1'b1;

      unique case (state)
        IDLE: begin
          if (stop_cond && armed && !lock_blocked) begin
            for (int k = 0; k < 4; k++)
              if (cell_in_range(cells[k], COLS, ROWS))
                grid[cells[k].row][cells[k].col] <= 1'b1;
            r     <= row_t'(ROWS - 1);
            armed <= 1'b0;
            state <= SCAN;
`ifdef TOPOUT_DETECT_EN
            if (top_hit)
              game_over <= 1'b1;
`endif
          end
        end

        SCAN: begin
          if (&grid[r]) begin
            state <= SHIFT;
          end else if (r == '0) begin
            state         <= DONE;
            lock_done     <= 1'b1;
            lines_cleared <= count;
            total_lines   <= total_next;
          end else begin
            r <= r - 5'd1;
          end
        end

        // Collapse everything above r by one row; r is rescanned since a full row may drop in.
        SHIFT: begin
          for (int i = 1; i < ROWS; i++)
            if (i <= int'(r))
              grid[i] <= grid[i-1];
          grid[0] <= '0;
          count   <= count + 3'd1;
          state   <= SCAN;
        end

        DONE: begin
          count <= '0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_playfield_lock.sv
// Self-checking bench: directed lock/clear scenarios plus randomized pieces, all compared
// every cycle against a whole-lock behavioural model of the playfield.
module tb_playfield_lock;

  logic        frame_clk = 1'b0;
  logic        reset = 1'b0;
  logic        piece_valid = 1'b0;
  logic [15:0] cell_col = '0;
  logic [19:0] cell_row = '0;
  logic [3:0]  rd_col = '0;
  logic [4:0]  rd_row = '0;
  logic        rd_occupied, stop, busy, lock_done, game_over;
  logic [2:0]  lines_cleared;
  logic [9:0]  total_lines;

  int total = 0;
  int bad   = 0;

  playfield_lock dut (
    .frame_clk     (frame_clk),
    .reset         (reset),
    .piece_valid   (piece_valid),
    .cell_col      (cell_col),
    .cell_row      (cell_row),
    .rd_col        (rd_col),
    .rd_row        (rd_row),
    .rd_occupied   (rd_occupied),
    .stop          (stop),
    .busy          (busy),
    .lock_done     (lock_done),
    .lines_cleared (lines_cleared),
    .total_lines   (total_lines),
    .game_over     (game_over)
  );

  always #5 frame_clk = ~frame_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  // Model: a lock is resolved at once (place cells, drop full rows, compact), then the
  // model just counts out the busy window ROWS + 2k + 1 cycles long.
  bit m_grid [20][10];
  int m_cnt, m_k, m_lc, m_total;
  bit m_armed, m_go;

  function automatic void m_reset();
    foreach (m_grid[i, j]) m_grid[i][j] = 1'b0;
    m_cnt = 0; m_k = 0; m_lc = 0; m_total = 0; m_armed = 1'b1; m_go = 1'b0;
  endfunction

  function automatic bit m_stop_cond();
    for (int k = 0; k < 4; k++) begin
      int c = int'(cell_col[4*k +: 4]);
      int r = int'(cell_row[5*k +: 5]);
      if (piece_valid && c < 10 && r < 20)
        if (r == 19 || m_grid[r+1][c]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void m_lock();
    bit ng [20][10];
    int w = 19;
    for (int k = 0; k < 4; k++) begin
      int c = int'(cell_col[4*k +: 4]);
      int r = int'(cell_row[5*k +: 5]);
      if (c < 10 && r < 20) begin
        m_grid[r][c] = 1'b1;
`ifdef TOPOUT_DETECT_EN
        if (r == 0) m_go = 1'b1;
`endif
      end
    end
    foreach (ng[i, j]) ng[i][j] = 1'b0;
    m_k = 0;
    for (int i = 19; i >= 0; i--) begin
      bit full = 1'b1;
      for (int j = 0; j < 10; j++) full &= m_grid[i][j];
      if (full) m_k++;
      else begin
        for (int j = 0; j < 10; j++) ng[w][j] = m_grid[i][j];
        w--;
      end
    end
    m_grid  = ng;
    m_cnt   = 21 + 2 * m_k;
    m_armed = 1'b0;
  endfunction

  always @(posedge frame_clk or negedge reset) begin
    if (!reset) m_reset();
    else begin
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 1) begin
          m_lc    = m_k;
          m_total = (m_total + m_k > 1023) ? 1023 : m_total + m_k;
        end
      end else if (m_armed && !m_go && m_stop_cond()) begin
        m_lock();
      end
      if (!piece_valid) m_armed = 1'b1;
    end
  end

  // Every-cycle comparison, sampled on the falling edge.
  always @(negedge frame_clk) begin
    if (reset) begin
      check("busy", busy, m_cnt > 0);
      check("lock_done", lock_done, m_cnt == 1);
      check("stop", stop, (m_cnt > 0) || m_stop_cond());
      check("lines_cleared", lines_cleared, m_lc);
      check("total_lines", total_lines, m_total);
      check("game_over", game_over, m_go);
      if (m_cnt == 0)
        check("rd_occupied", rd_occupied,
              (rd_col < 10 && rd_row < 20) ? m_grid[rd_row][rd_col] : 1'b0);
    end
  end

  function automatic logic [15:0] pc(input int a, input int b, input int c, input int d);
    return {4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  function automatic logic [19:0] pr(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  task automatic present(input logic [15:0] cc, input logic [19:0] rr);
    @(posedge frame_clk); #1 piece_valid = 1'b0;
    @(posedge frame_clk); #1 cell_col = cc; cell_row = rr; piece_valid = 1'b1;
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 10) begin @(negedge frame_clk); n++; end
    check("lock_start", busy, 1);
  endtask

  task automatic wait_done(output int off);
    off = 0;
    while (!lock_done && off < 200) begin @(negedge frame_clk); off++; end
  endtask

  // Present a piece, check stop is immediate, then the lock_done offset from the first busy cycle.
  task automatic lock_piece(input logic [15:0] cc, input logic [19:0] rr,
                            input int exp_off, input int exp_lines);
    int off;
    present(cc, rr);
    @(negedge frame_clk);
    check("stop_immediate", stop, 1);
    @(negedge frame_clk);
    wait_busy();
    wait_done(off);
    check("lock_done_offset", off, exp_off);
    @(posedge frame_clk); #1 piece_valid = 1'b0;
    @(negedge frame_clk);
    check("lines_after_lock", lines_cleared, exp_lines);
  endtask

  task automatic rd_check(input int c, input int r, input logic exp);
    @(posedge frame_clk); #1 rd_col = 4'(c); rd_row = 5'(r);
    @(negedge frame_clk);
    check("rd_literal", rd_occupied, exp);
  endtask

  task automatic do_reset();
    @(negedge frame_clk); #1 reset = 1'b0; piece_valid = 1'b0;
    @(negedge frame_clk); #1 reset = 1'b1;
  endtask

  task automatic rand_piece(output logic [15:0] cc, output logic [19:0] rr);
    int t = $urandom_range(0, 3);
    int c = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 12) : $urandom_range(0, 9);
    int r = $urandom_range(8, 19);
    if (t == 1 && $urandom_range(0, 1) == 1) c = 4 * $urandom_range(0, 1);
    unique case (t)
      0: begin cc = pc(c, c, c, c);             rr = pr(r, r+1, r+2, r+3); end
      1: begin cc = pc(c, c+1, c+2, c+3);       rr = pr(r, r, r, r);       end
      2: begin cc = pc(c, c+1, c, c+1);         rr = pr(r, r, r+1, r+1);   end
      default: begin cc = pc(c, c, c, c);       rr = pr(r, r, r, r);       end
    endcase
  endtask

  initial begin
    int off, nbusy;
    logic [15:0] cc;
    logic [19:0] rr;

    m_reset();
    #12;
    check("reset_busy", busy, 0);
    check("reset_stop", stop, 0);
    check("reset_lock_done", lock_done, 0);
    check("reset_total", total_lines, 0);
    check("reset_game_over", game_over, 0);
    check("reset_rd", rd_occupied, 0);
    #10 reset = 1'b1;

    // Vertical piece on an empty floor.
    lock_piece(pc(0, 0, 0, 0), pr(16, 17, 18, 19), 20, 0);
    rd_check(0, 19, 1'b1);
    rd_check(0, 15, 1'b0);
    rd_check(12, 19, 1'b0);

    // One line: row 19 cols 0-5 plus a cell above col 2, then a horizontal I completes it.
    do_reset();
    for (int c = 0; c < 6; c++) lock_piece(pc(c, c, c, c), pr(19, 19, 19, 19), 20, 0);
    lock_piece(pc(2, 2, 2, 2), pr(18, 18, 18, 18), 20, 0);
    lock_piece(pc(6, 7, 8, 9), pr(19, 19, 19, 19), 22, 1);
    check("total_one_line", total_lines, 1);
    rd_check(2, 19, 1'b1);
    rd_check(3, 19, 1'b0);
    rd_check(2, 18, 1'b0);

    // Tetris: four full rows.
    do_reset();
    for (int c = 0; c < 9; c++) lock_piece(pc(c, c, c, c), pr(16, 17, 18, 19), 20, 0);
    lock_piece(pc(9, 9, 9, 9), pr(16, 17, 18, 19), 28, 4);
    check("total_tetris", total_lines, 4);
    for (int r = 16; r < 20; r++)
      for (int c = 0; c < 10; c += 3) rd_check(c, r, 1'b0);

    // Holding piece_valid after a lock must not lock again; a one-cycle drop re-arms.
    present(pc(9, 9, 9, 9), pr(16, 17, 18, 19));
    @(negedge frame_clk);
    @(negedge frame_clk);
    wait_busy();
    wait_done(off);
    check("hold_first_offset", off, 20);
    nbusy = 0;
    repeat (30) begin @(negedge frame_clk); if (busy) nbusy++; end
    check("hold_no_relock", nbusy, 0);
    @(posedge frame_clk); #1 piece_valid = 1'b0;
    @(posedge frame_clk); #1 piece_valid = 1'b1;
    @(negedge frame_clk);
    @(negedge frame_clk);
    wait_busy();
    wait_done(off);
    check("rearm_offset", off, 20);
    @(posedge frame_clk); #1 piece_valid = 1'b0;

    // Reset while collapsing a full row.
    for (int c = 0; c < 8; c++) lock_piece(pc(c, c, c, c), pr(19, 19, 19, 19), 20, 0);
    rd_col = 4'd9; rd_row = 5'd19;
    present(pc(8, 8, 8, 8), pr(19, 19, 19, 19));
    @(negedge frame_clk);
    @(negedge frame_clk);
    wait_busy();
    @(negedge frame_clk);
    #1 reset = 1'b0; piece_valid = 1'b0;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_total", total_lines, 0);
    check("midreset_lock_done", lock_done, 0);
    check("midreset_rd", rd_occupied, 0);
    check("midreset_stop", stop, 0);
    @(negedge frame_clk); #1 reset = 1'b1;

`ifdef TOPOUT_DETECT_EN
    for (int b = 16; b >= 0; b -= 4) lock_piece(pc(0, 0, 0, 0), pr(b, b+1, b+2, b+3), 20, 0);
    check("topout_flag", game_over, 1);
    present(pc(5, 5, 5, 5), pr(16, 17, 18, 19));
    nbusy = 0;
    repeat (30) begin @(negedge frame_clk); if (busy || lock_done) nbusy++; end
    check("topout_no_lock", nbusy, 0);
    check("topout_stop", stop, 1);
    check("topout_sticky", game_over, 1);
    do_reset();
`endif

    // Randomized pieces with random read addresses every cycle.
    do_reset();
    repeat (150) begin
      @(posedge frame_clk); #1 piece_valid = 1'b0;
      rd_col = 4'($urandom_range(0, 11)); rd_row = 5'($urandom_range(0, 21));
      repeat ($urandom_range(0, 2)) begin
        @(posedge frame_clk); #1 rd_col = 4'($urandom_range(0, 11)); rd_row = 5'($urandom_range(0, 21));
      end
      rand_piece(cc, rr);
      @(posedge frame_clk); #1 cell_col = cc; cell_row = rr; piece_valid = 1'b1;
      repeat ($urandom_range(1, 40)) begin
        @(posedge frame_clk); #1 rd_col = 4'($urandom_range(0, 11)); rd_row = 5'($urandom_range(0, 21));
      end
    end
    @(posedge frame_clk); #1 piece_valid = 1'b0;
    repeat (40) @(negedge frame_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
